// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline registers: stage widths,
// the bubble control value and the per-stage control field layout.
`timescale 1ns/1ps
package pipe_pkg;

    localparam int STAGE_CTRL_W = 16;
    localparam int STAGE_DATA_W = 128;
    localparam int STAGE_PC_W   = 32;

    // A bubble leaves every write enable and side-effecting select off.
    localparam logic [STAGE_CTRL_W-1:0] BUBBLE_CTRL_DEFAULT = '0;

    typedef struct packed {
        logic       reg_we;
        logic       mem_we;
        logic       mem_re;
        logic [1:0] alu_src;
        logic [3:0] alu_op;
        logic [1:0] wb_sel;
        logic [1:0] pc_sel;
        logic [2:0] rsvd;
    } stage_ctrl_t;

    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Beat channel between two pipeline stages: control, payload and exam pc.
`timescale 1ns/1ps
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = STAGE_CTRL_W,
    parameter int DATA_W = STAGE_DATA_W,
    parameter int PC_W   = STAGE_PC_W
);
    // Handshake: a beat moves on a posedge where valid && ready are both 1.
    // valid must never be derived from ready; ready may depend on valid.
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;

    modport master (output valid, output ctrl, output data, output pc, input ready);
    modport slave  (input valid, input ctrl, input data, input pc, output ready);
endinterface

// File: rtl/pipe_stage_slot.sv
// One held beat: valid flag plus ctrl/data/pc registers with load and clear.
// Clear empties the slot and returns ctrl/pc to bubble values; data is kept.
`timescale 1ns/1ps
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int                CTRL_W      = STAGE_CTRL_W,
    parameter int                DATA_W      = STAGE_DATA_W,
    parameter int                PC_W        = STAGE_PC_W,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = BUBBLE_CTRL_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    input  logic [PC_W-1:0]   d_pc,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data,
    output logic [PC_W-1:0]   pc
);

    logic              valid_d, valid_q;
    logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
    logic [DATA_W-1:0] data_d,  data_q;
    logic [PC_W-1:0]   pc_d,    pc_q;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = BUBBLE_CTRL;
            pc_d    = '0;
        end else if (load) begin
            valid_d = 1'b1;
            ctrl_d  = d_ctrl;
            data_d  = d_data;
            pc_d    = d_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= BUBBLE_CTRL;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign ctrl  = ctrl_q;
    assign data  = data_q;
    assign pc    = pc_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready, stall and flush.
// Define PIPE_STAGE_SKID_EN for a second (skid) entry and a registered in_ready.
`timescale 1ns/1ps
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W      = STAGE_CTRL_W,
    parameter int                DATA_W      = STAGE_DATA_W,
    parameter int                PC_W        = STAGE_PC_W,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = BUBBLE_CTRL_DEFAULT
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic                    flush,
    pipe_stage_reg_if.slave         up,
    pipe_stage_reg_if.master        dn,
    output logic [1:0]              dbg_occ
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [PC_W-1:0]   main_pc;
    logic              main_load, main_clear;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;
    logic [PC_W-1:0]   main_d_pc;
    logic              skid_valid;
    logic              xfer_in, xfer_out;

    assign xfer_in  = up.valid && up.ready;
    assign xfer_out = main_valid && dn.ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_load, skid_clear, main_sel_skid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [PC_W-1:0]   skid_pc;

    // Only the skid flop gates acceptance, so out_ready never reaches in_ready.
    assign up.ready = !skid_valid || flush;

    always_comb begin
        main_load     = 1'b0;
        main_clear    = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (!main_valid || xfer_out) begin
            if (skid_valid) begin
                main_load     = 1'b1;
                main_sel_skid = 1'b1;
                skid_clear    = 1'b1;
            end else if (xfer_in) begin
                main_load = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else if (xfer_in) begin
            skid_load = 1'b1;
        end
    end

    assign main_d_ctrl = main_sel_skid ? skid_ctrl : up.ctrl;
    assign main_d_data = main_sel_skid ? skid_data : up.data;
    assign main_d_pc   = main_sel_skid ? skid_pc   : up.pc;

    pipe_stage_slot #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .PC_W        (PC_W),
        .BUBBLE_CTRL (BUBBLE_CTRL)
    ) u_skid (
        .clk    (clk),
        .rst    (RESET),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_ctrl (up.ctrl),
        .d_data (up.data),
        .d_pc   (up.pc),
        .valid  (skid_valid),
        .ctrl   (skid_ctrl),
        .data   (skid_data),
        .pc     (skid_pc)
    );
`else
    assign skid_valid = 1'b0;
    assign up.ready   = !main_valid || dn.ready || flush;

    always_comb begin
        main_load  = !flush && xfer_in;
        main_clear = flush || (xfer_out && !xfer_in);
    end

    assign main_d_ctrl = up.ctrl;
    assign main_d_data = up.data;
    assign main_d_pc   = up.pc;
`endif

    pipe_stage_slot #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .PC_W        (PC_W),
        .BUBBLE_CTRL (BUBBLE_CTRL)
    ) u_main (
        .clk    (clk),
        .rst    (RESET),
        .load   (main_load),
        .clear  (main_clear),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .d_pc   (main_d_pc),
        .valid  (main_valid),
        .ctrl   (main_ctrl),
        .data   (main_data),
        .pc     (main_pc)
    );

    assign dn.valid = main_valid;
    assign dn.ctrl  = main_ctrl;
    assign dn.data  = main_data;
    assign dn.pc    = main_pc;
    assign dbg_occ  = occ_count(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a queue model of the stage.
`timescale 1ns/1ps
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = STAGE_CTRL_W;
    localparam int DW = STAGE_DATA_W;
    localparam int PW = STAGE_PC_W;
    localparam int BW = CW + DW + PW;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP  = 2;
    localparam bit SKID = 1'b1;
`else
    localparam int CAP  = 1;
    localparam bit SKID = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] dbg_occ;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW), .PC_W(PW)) up_if ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW), .PC_W(PW)) dn_if ();

    pipe_stage_reg dut (
        .clk     (clk),
        .RESET   (rst),
        .flush   (flush),
        .up      (up_if.slave),
        .dn      (dn_if.master),
        .dbg_occ (dbg_occ)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    bit seen_300c = 1'b0;
    int in_xfers = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Held beats in arrival order; the head is what the stage presents.
    logic [BW-1:0] exp_q[$];

    function automatic logic exp_in_ready();
        if (flush) return 1'b1;
        if (exp_q.size() < CAP) return 1'b1;
        return (CAP == 1) && dn_if.ready;
    endfunction

    always @(posedge clk) begin
        logic ir;
        ir = exp_in_ready();
        if (rst) begin
            exp_q.delete();
        end else begin
            if (up_if.valid && ir) in_xfers++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() > 0 && dn_if.ready) void'(exp_q.pop_front());
                if (up_if.valid && ir) exp_q.push_back({up_if.ctrl, up_if.data, up_if.pc});
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [BW-1:0] head;
        if (chk_en) begin
            check("in_ready", up_if.ready, exp_in_ready());
            check("out_valid", dn_if.valid, exp_q.size() > 0);
            check("occupancy", dbg_occ, exp_q.size());
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                check("out_ctrl", dn_if.ctrl, head[BW-1 -: CW]);
                check("out_data", dn_if.data, head[PW +: DW]);
                check("out_pc", dn_if.pc, head[PW-1:0]);
            end else begin
                check("empty_ctrl", dn_if.ctrl, BUBBLE_CTRL_DEFAULT);
                check("empty_pc", dn_if.pc, '0);
            end
            if (dn_if.valid && dn_if.pc == 32'h300C) seen_300c = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic v, input logic [CW-1:0] c, input logic [PW-1:0] p);
        up_if.valid = v;
        up_if.ctrl  = c;
        up_if.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        up_if.pc    = p;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int cycles;
        logic acc;

        rst = 1'b1;
        flush = 1'b0;
        dn_if.ready = 1'b1;
        drive_beat(1'b1, 16'h1234, 32'h0000_0FF0);

        // 1. reset held two cycles with in_valid high
        cyc();
        chk_en = 1'b1;
        cyc();
        check("rst_out_valid", dn_if.valid, 1'b0);
        check("rst_out_ctrl", dn_if.ctrl, 16'h0000);
        check("rst_out_pc", dn_if.pc, 32'h0);
        rst = 1'b0;
        up_if.valid = 1'b0;
        cyc();
        check("post_rst_in_ready", up_if.ready, 1'b1);

        // 2. back-to-back stream
        drive_beat(1'b1, 16'h0001, 32'h3000);
        cyc();
        check("stream0_pc", dn_if.pc, 32'h3000);
        drive_beat(1'b1, 16'h0002, 32'h3004);
        cyc();
        check("stream1_pc", dn_if.pc, 32'h3004);
        check("stream1_valid", dn_if.valid, 1'b1);
        drive_beat(1'b1, 16'h0003, 32'h3008);
        cyc();
        check("stream2_pc", dn_if.pc, 32'h3008);
        up_if.valid = 1'b0;
        cyc();
        check("stream_drained", dn_if.valid, 1'b0);

        // 3. five-cycle stall
        dn_if.ready = 1'b0;
        drive_beat(1'b1, 16'h00A5, 32'h3100);
        cyc();
        drive_beat(1'b1, 16'h005A, 32'h3104);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", up_if.ready, SKID && (i == 0));
            check("stall_ctrl", dn_if.ctrl, 16'h00A5);
            check("stall_pc", dn_if.pc, 32'h3100);
            acc = up_if.ready;
            cyc();
            if (acc) up_if.valid = 1'b0;
        end
        dn_if.ready = 1'b1;
        cyc();
        up_if.valid = 1'b0;
        check("release_pc", dn_if.pc, 32'h3104);
        check("release_ctrl", dn_if.ctrl, 16'h005A);
        cyc();
        check("release_drained", dn_if.valid, 1'b0);

        // 4. flush at occupancy 1 with a concurrent beat
        seen_300c = 1'b0;
        dn_if.ready = 1'b0;
        drive_beat(1'b1, 16'h0011, 32'h3200);
        cyc();
        check("pre_flush_pc", dn_if.pc, 32'h3200);
        drive_beat(1'b1, 16'h0022, 32'h300C);
        flush = 1'b1;
        #1;
        check("flush_in_ready", up_if.ready, 1'b1);
        cyc();
        flush = 1'b0;
        up_if.valid = 1'b0;
        check("flush_out_valid", dn_if.valid, 1'b0);
        check("flush_out_ctrl", dn_if.ctrl, 16'h0000);
        dn_if.ready = 1'b1;
        cyc();
        cyc();

        // 5. reset and flush together during a full stall
        dn_if.ready = 1'b0;
        drive_beat(1'b1, 16'h0033, 32'h3300);
        cyc();
        drive_beat(1'b1, 16'h0044, 32'h3304);
        cyc();
        rst = 1'b1;
        flush = 1'b1;
        cyc();
        rst = 1'b0;
        flush = 1'b0;
        up_if.valid = 1'b0;
        check("rf_out_valid", dn_if.valid, 1'b0);
        check("rf_out_ctrl", dn_if.ctrl, 16'h0000);
        check("rf_out_pc", dn_if.pc, 32'h0);
        check("rf_occ", dbg_occ, 2'd0);
        dn_if.ready = 1'b1;
        drive_beat(1'b1, 16'h0055, 32'h3010);
        #1;
        check("rf_in_ready", up_if.ready, 1'b1);
        cyc();
        up_if.valid = 1'b0;
        check("rf_next_pc", dn_if.pc, 32'h3010);
        check("rf_next_valid", dn_if.valid, 1'b1);
        cyc();
        check("flushed_300c_absent", seen_300c, 1'b0);

        // 6. random traffic
        base = in_xfers;
        cycles = 0;
        while ((in_xfers - base) < 10000 && cycles < 60000) begin
            drive_beat($urandom_range(0, 3) != 0, 16'($urandom()), $urandom());
            dn_if.ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 63) == 0;
            cyc();
            cycles++;
        end
        check("random_beats_done", (in_xfers - base) >= 10000, 1'b1);
        up_if.valid = 1'b0;
        flush = 1'b0;
        dn_if.ready = 1'b1;
        repeat (4) cyc();
        check("final_drained", dn_if.valid, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
